add_result_stage: RTL and testbench
===================================

Name: add_result_stage

Overview:
- Downstream stage of the 32-bit ADD unit in the ALU.
- Takes the operands presented to ADD and the sum ADD returns combinationally, and derives the status flags Z, N, C and V.
- Buffers result and flags in a small in-order FIFO with valid/ready handshakes toward writeback.
- Also keeps a sticky overflow flag and a count of accepted operations for the processor status register.

Parameters:
- WIDTH, 32, datapath width of operands and sum.
- DEPTH, 2, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the accepted-operation counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents a valid op_a/op_b/sum triple.
- in_ready  output  1  stage can accept this cycle.
- op_a  input  WIDTH  first operand as driven into ADD.
- op_b  input  WIDTH  second operand as driven into ADD.
- sum  input  WIDTH  ADD output for op_a and op_b.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream consumes head this cycle.
- out_result  output  WIDTH  head entry's sum.
- out_flags  output  4  head flags, {V,C,N,Z}; bit 0 is Z.
- sticky_ovf  output  1  set by any accepted op with V=1.
- clr_sticky  input  1  synchronous clear of sticky_ovf.
- op_count  output  CNT_W  number of accepted ops; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - count, read and write pointers, sticky_ovf and op_count go to 0.
  - out_valid=0; out_result and out_flags read 0.
  - in_ready=1 while rst is high and after it is released.
- Flag derivation (combinational on the inputs, captured on push):
  - Z = (sum==0).
  - N = sum[WIDTH-1].
  - C = (sum < op_a), unsigned compare; equivalent to carry-out.
  - V = (op_a[MSB]==op_b[MSB]) && (sum[MSB]!=op_a[MSB]).
- Push: in_valid && in_ready.
  - Writes {sum, flags} at the write pointer; pointer advances and wraps modulo DEPTH.
- Pop: out_valid && out_ready.
  - Read pointer advances and wraps modulo DEPTH.
- in_ready = (count != DEPTH), decoded from registered count only; no combinational path from out_ready.
- out_valid = (count != 0). out_result and out_flags come straight from the head entry, with no output register.
- Latency: a pushed entry is visible on the outputs in the cycle after the push.
- No bypass when empty: a push into an empty FIFO is not visible on the outputs in the same cycle.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, including the count==DEPTH-1 case.
  - When full, in_ready=0, so a same-cycle push is impossible and the pop alone frees a slot for the next cycle.
- Ordering: strictly FIFO.
- sticky_ovf:
  - Next value = (sticky_ovf && !clr_sticky) || (push && V).
  - Set wins over a same-cycle clear.
- op_count: +1 per push, wraps from all-ones to 0.
- in_valid while in_ready=0: no state change. Upstream must hold the triple stable until accepted.
- Unhandshaken out_ready (out_ready=1 with out_valid=0): ignored.
- Reset mid-operation: buffered entries are discarded and no partial pop or push occurs.

Decomposition:
- Shared package alu_pkg holds:
  - flag index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3;
  - typedef alu_flags_t (4 bits);
  - WIDTH default 32.
- One natural sub-module, add_flag_calc: purely combinational, op_a/op_b/sum in, alu_flags_t out; reusable by the future SUB unit.
- The FIFO and counters stay inline in add_result_stage.

Test Plan:
1. Carry and zero: op_a=4294967295, op_b=1, sum=0, out_ready=1 → next cycle out_result=0, out_flags=4'b0101 (C,Z), sticky_ovf stays 0, op_count=1.
2. Signed overflow: op_a=32'h7FFFFFFF, op_b=1, sum=32'h80000000 → out_flags=4'b1010 (V,N); sticky_ovf=1 next cycle. Then clr_sticky pulse with no push → sticky_ovf=0.
3. Back-pressure and fill: out_ready=0; push 555+246 (sum 801), then 0+12345678.
   - in_ready=0 after the 2nd push; a 3rd triple 6+9 is held and not accepted.
   - Raise out_ready → outputs 801, then 12345678, then 15 (flags 0), in order.
   - op_count=3 at the end.
4. Simultaneous push/pop at count=1: keep out_ready=1 with in_valid every cycle → count stays 1, in_ready stays 1, one result per cycle, order preserved.
5. Set/clear collision: same cycle clr_sticky=1 and push of an overflowing op (op_a=op_b=32'h80000000, sum=0) → sticky_ovf=1 and head flags=4'b1101 (V,C,Z).
6. Reset mid-operation: with 2 entries buffered and sticky_ovf=1, pulse rst asynchronously between edges → out_valid=0 and in_ready=1 immediately; sticky_ovf=0 and op_count=0. After release, a push of 6+9 appears as 15 one cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result stages.
//   ALU_WIDTH       : default datapath width of the ALU units
//   FLAG_Z..FLAG_V  : bit positions of the status flags inside alu_flags_t
//   alu_flags_t     : packed status flag vector {V,C,N,Z}, bit 0 is Z
// ----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;
   localparam int FLAG_W = 4;

   typedef logic [FLAG_W-1:0] alu_flags_t;

endpackage

// File: rtl/add_flag_calc.sv
// ----------------------------------------------------------------------------
// add_flag_calc
// Purely combinational status flag derivation for an addition result.
// Ports:
//   op_a, op_b : operands that were driven into the adder
//   sum        : adder output for op_a + op_b
//   flags      : {V,C,N,Z} derived from the three values above
// ----------------------------------------------------------------------------
module add_flag_calc
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] sum,
   output alu_flags_t       flags
);

   // Carry is recovered from the truncated sum: an unsigned wrap-around
   // always leaves the sum smaller than the first operand, so no extra
   // adder bit is needed. Overflow is the classic sign rule: both operands
   // share a sign and the sum's sign differs from it.
   always_comb begin
      flags         = '0;
      flags[FLAG_Z] = (sum == '0);
      flags[FLAG_N] = sum[WIDTH-1];
      flags[FLAG_C] = (sum < op_a);
      flags[FLAG_V] = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                      (sum[WIDTH-1] != op_a[WIDTH-1]);
   end

endmodule

// File: rtl/add_result_stage.sv
// ----------------------------------------------------------------------------
// add_result_stage
// Downstream stage of the 32-bit ADD unit. Derives Z/N/C/V for each sum,
// buffers {sum, flags} in a small in-order FIFO towards writeback, and keeps
// a sticky overflow flag plus a count of accepted operations.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid, in_ready    : upstream handshake for the op_a/op_b/sum triple
//   op_a, op_b, sum       : adder operands and the adder's result
//   out_valid, out_ready  : downstream handshake for the head entry
//   out_result, out_flags : head entry's sum and {V,C,N,Z} flags
//   sticky_ovf, clr_sticky: sticky overflow status and its synchronous clear
//   op_count              : accepted operations, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module add_result_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output alu_flags_t       out_flags,
   output logic             sticky_ovf,
   input  logic             clr_sticky,
   output logic [CNT_W-1:0] op_count
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FILL_W = $clog2(DEPTH + 1);
   localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(DEPTH);

   alu_flags_t       newFlags;
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [FILL_W-1:0] fillCount;
   logic             doPush;
   logic             doPop;

   logic [WIDTH-1:0] resultMem [DEPTH];
   alu_flags_t       flagsMem  [DEPTH];

   add_flag_calc #(
      .WIDTH (WIDTH)
   ) flagCalc (
      .op_a  (op_a),
      .op_b  (op_b),
      .sum   (sum),
      .flags (newFlags)
   );

   // Both handshake qualifiers come only from the registered fill level, so
   // in_ready never depends combinationally on out_ready. When full, the pop
   // alone frees a slot and the upstream push lands on the following cycle.
   // The head entry is gated to zero while empty so stale storage never
   // leaks onto the outputs (and they read zero straight out of reset).
   always_comb begin
      in_ready   = (fillCount != FULL_FILL);
      out_valid  = (fillCount != '0);
      doPush     = in_valid && in_ready;
      doPop      = out_valid && out_ready;
      out_result = out_valid ? resultMem[rdPtr] : '0;
      out_flags  = out_valid ? flagsMem[rdPtr]  : '0;
   end

   // Entry storage needs no reset: nothing is visible unless the fill level
   // says the slot holds a live entry.
   always_ff @(posedge clk) begin
      if (doPush) begin
         resultMem[wrPtr] <= sum;
         flagsMem[wrPtr]  <= newFlags;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two. A simultaneous
   // push and pop leaves the fill level untouched, including one-below-full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fillCount <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + PTR_W'(1);
         end
         if (doPop) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         if (doPush && !doPop) begin
            fillCount <= fillCount + FILL_W'(1);
         end else if (doPop && !doPush) begin
            fillCount <= fillCount - FILL_W'(1);
         end
      end
   end

   // Status register side: an accepted overflowing add sets the sticky bit
   // even when software clears it in the same cycle, so no overflow is lost.
   // The operation counter simply wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_ovf <= 1'b0;
         op_count   <= '0;
      end else begin
         sticky_ovf <= (sticky_ovf && !clr_sticky) || (doPush && newFlags[FLAG_V]);
         if (doPush) begin
            op_count <= op_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_add_result_stage.sv
// ----------------------------------------------------------------------------
// tb_add_result_stage
// Self-checking bench for add_result_stage. A queue-based reference model
// computes flags from wide integer arithmetic and tracks FIFO contents,
// sticky overflow and the operation count independently of the RTL.
// ----------------------------------------------------------------------------
module tb_add_result_stage;

   localparam int WIDTH = 32;
   localparam int DEPTH = 2;
   localparam int CNT_W = 16;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sum;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [3:0]       out_flags;
   logic             sticky_ovf;
   logic             clr_sticky;
   logic [CNT_W-1:0] op_count;

   int nChecks = 0;
   int nFails  = 0;

   logic [35:0]      modelQ [$];
   logic             modelSticky;
   logic [CNT_W-1:0] modelCount;

   add_result_stage #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .sum        (sum),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .sticky_ovf (sticky_ovf),
      .clr_sticky (clr_sticky),
      .op_count   (op_count)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Flags from first principles: carry from a 33-bit add, overflow from
   // whether the true signed sum fits in 32 bits.
   function automatic logic [3:0] expFlags(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] s);
      logic [32:0] wide;
      longint      sres;
      logic        v;
      wide = {1'b0, a} + {1'b0, b};
      sres = longint'($signed(a)) + longint'($signed(b));
      v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      return {v, wide[32], s[31], (s == 32'd0)};
   endfunction

   // Present a triple; sum is always the true adder output.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic v);
      op_a     = a;
      op_b     = b;
      sum      = a + b;
      in_valid = v;
   endtask

   // Advance one clock, updating the model from the inputs seen at the edge.
   // Leaves the bench 1 unit after the rising edge.
   task automatic step();
      logic mPush, mPop, mV;
      mPush = in_valid && (modelQ.size() != DEPTH);
      mPop  = out_ready && (modelQ.size() != 0);
      mV    = expFlags(op_a, op_b, sum) >> 3;
      @(posedge clk);
      #1;
      if (mPop) void'(modelQ.pop_front());
      if (mPush) begin
         modelQ.push_back({expFlags(op_a, op_b, sum), sum});
         modelCount = modelCount + 1'b1;
      end
      modelSticky = (modelSticky && !clr_sticky) || (mPush && mV);
   endtask

   task automatic modelReset();
      modelQ.delete();
      modelSticky = 1'b0;
      modelCount  = '0;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      clr_sticky = 1'b0;
      op_a       = '0;
      op_b       = '0;
      sum        = '0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      nChecks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL reset_handshake: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
      end
      nChecks++;
      if (out_result !== 32'd0 || out_flags !== 4'd0) begin
         nFails++;
         $display("[TB] FAIL reset_outputs: result=%h flags=%b, want 0/0000", out_result, out_flags);
      end
      nChecks++;
      if (sticky_ovf !== 1'b0 || op_count !== 16'd0) begin
         nFails++;
         $display("[TB] FAIL reset_status: sticky=%b count=%0d, want 0/0", sticky_ovf, op_count);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_carry_zero();
      out_ready = 1'b1;
      applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b1);
      #1;
      nChecks++;
      if (out_valid !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL no_bypass: out_valid=%b, want 0", out_valid);
      end
      step();
      in_valid = 1'b0;
      nChecks++;
      if (out_valid !== 1'b1 || out_result !== 32'd0 || out_flags !== 4'b0101) begin
         nFails++;
         $display("[TB] FAIL carry_zero: valid=%b result=%h flags=%b, want 1/0/0101",
                  out_valid, out_result, out_flags);
      end
      nChecks++;
      if (sticky_ovf !== 1'b0 || op_count !== 16'd1) begin
         nFails++;
         $display("[TB] FAIL carry_zero_status: sticky=%b count=%0d, want 0/1", sticky_ovf, op_count);
      end
      step();
   endtask

   task automatic test_overflow();
      out_ready = 1'b1;
      applyStimulus(32'h7FFF_FFFF, 32'd1, 1'b1);
      step();
      in_valid = 1'b0;
      nChecks++;
      if (out_result !== 32'h8000_0000 || out_flags !== 4'b1010 || sticky_ovf !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL overflow: result=%h flags=%b sticky=%b, want 80000000/1010/1",
                  out_result, out_flags, sticky_ovf);
      end
      step();
      clr_sticky = 1'b1;
      step();
      clr_sticky = 1'b0;
      nChecks++;
      if (sticky_ovf !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL clear_sticky: sticky=%b, want 0", sticky_ovf);
      end
   endtask

   task automatic test_backpressure();
      logic [CNT_W-1:0] startCount;
      startCount = op_count;
      out_ready  = 1'b0;
      applyStimulus(32'd555, 32'd246, 1'b1);
      step();
      applyStimulus(32'd0, 32'd12345678, 1'b1);
      step();
      nChecks++;
      if (in_ready !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL full_ready: in_ready=%b, want 0", in_ready);
      end
      applyStimulus(32'd6, 32'd9, 1'b1);
      step();
      step();
      nChecks++;
      if (in_ready !== 1'b0 || out_result !== 32'd801 || op_count !== startCount + 16'd2) begin
         nFails++;
         $display("[TB] FAIL held_triple: in_ready=%b head=%0d count=%0d, want 0/801/%0d",
                  in_ready, out_result, op_count, startCount + 16'd2);
      end
      out_ready = 1'b1;
      step();
      nChecks++;
      if (out_result !== 32'd12345678) begin
         nFails++;
         $display("[TB] FAIL order_second: head=%0d, want 12345678", out_result);
      end
      step();
      in_valid = 1'b0;
      nChecks++;
      if (out_valid !== 1'b1 || out_result !== 32'd15 || out_flags !== 4'b0000) begin
         nFails++;
         $display("[TB] FAIL order_third: valid=%b head=%0d flags=%b, want 1/15/0000",
                  out_valid, out_result, out_flags);
      end
      nChecks++;
      if (op_count !== startCount + 16'd3) begin
         nFails++;
         $display("[TB] FAIL bp_count: count=%0d, want %0d", op_count, startCount + 16'd3);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] prevSum;
      int          bad;
      bad       = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus($urandom, $urandom, 1'b1);
         prevSum = op_a + op_b;
         step();
         if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== prevSum) bad++;
      end
      in_valid = 1'b0;
      nChecks++;
      if (bad != 0) begin
         nFails++;
         $display("[TB] FAIL back_to_back: %0d bad cycles, want 0", bad);
      end
      step();
   endtask

   task automatic test_collision();
      out_ready  = 1'b0;
      clr_sticky = 1'b1;
      applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1);
      step();
      clr_sticky = 1'b0;
      in_valid   = 1'b0;
      nChecks++;
      if (sticky_ovf !== 1'b1 || out_flags !== 4'b1101) begin
         nFails++;
         $display("[TB] FAIL set_over_clear: sticky=%b flags=%b, want 1/1101", sticky_ovf, out_flags);
      end
      out_ready = 1'b1;
      step();
   endtask

   // Randomized traffic against the queue model, honouring the hold rule.
   task automatic test_random();
      logic [31:0] ops [4];
      logic [31:0] expHead;
      logic [3:0]  expHeadFlags;
      ops[0] = 32'h0000_0000;
      ops[1] = 32'hFFFF_FFFF;
      ops[2] = 32'h7FFF_FFFF;
      ops[3] = 32'h8000_0000;
      in_valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!(in_valid && !in_ready)) begin
            applyStimulus(($urandom_range(0, 3) == 0) ? ops[$urandom_range(0, 3)] : $urandom,
                          ($urandom_range(0, 3) == 0) ? ops[$urandom_range(0, 3)] : $urandom,
                          $urandom_range(0, 1) == 1);
         end
         out_ready  = $urandom_range(0, 2) != 0;
         clr_sticky = $urandom_range(0, 9) == 0;
         step();
         expHead      = (modelQ.size() != 0) ? modelQ[0][31:0]  : 32'd0;
         expHeadFlags = (modelQ.size() != 0) ? modelQ[0][35:32] : 4'd0;
         nChecks++;
         if (out_valid !== (modelQ.size() != 0) || in_ready !== (modelQ.size() != DEPTH)) begin
            nFails++;
            $display("[TB] FAIL rand_handshake cyc %0d: valid=%b ready=%b, want %b/%b", i,
                     out_valid, in_ready, modelQ.size() != 0, modelQ.size() != DEPTH);
         end
         nChecks++;
         if (out_result !== expHead || out_flags !== expHeadFlags) begin
            nFails++;
            $display("[TB] FAIL rand_head cyc %0d: result=%h flags=%b, want %h/%b", i,
                     out_result, out_flags, expHead, expHeadFlags);
         end
         nChecks++;
         if (sticky_ovf !== modelSticky || op_count !== modelCount) begin
            nFails++;
            $display("[TB] FAIL rand_status cyc %0d: sticky=%b count=%0d, want %b/%0d", i,
                     sticky_ovf, op_count, modelSticky, modelCount);
         end
      end
      in_valid   = 1'b0;
      clr_sticky = 1'b0;
      out_ready  = 1'b1;
      repeat (3) step();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      applyStimulus(32'h7FFF_FFFF, 32'd5, 1'b1);
      step();
      applyStimulus(32'd100, 32'd200, 1'b1);
      step();
      in_valid = 1'b0;
      nChecks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sticky_ovf !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL pre_reset: valid=%b ready=%b sticky=%b, want 1/0/1",
                  out_valid, in_ready, sticky_ovf);
      end
      #2 rst = 1'b1;
      #1;
      modelReset();
      nChecks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'd0) begin
         nFails++;
         $display("[TB] FAIL async_reset: valid=%b ready=%b result=%h, want 0/1/0",
                  out_valid, in_ready, out_result);
      end
      nChecks++;
      if (sticky_ovf !== 1'b0 || op_count !== 16'd0) begin
         nFails++;
         $display("[TB] FAIL async_reset_status: sticky=%b count=%0d, want 0/0", sticky_ovf, op_count);
      end
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(32'd6, 32'd9, 1'b1);
      step();
      in_valid = 1'b0;
      nChecks++;
      if (out_valid !== 1'b1 || out_result !== 32'd15 || op_count !== 16'd1) begin
         nFails++;
         $display("[TB] FAIL post_reset_push: valid=%b result=%0d count=%0d, want 1/15/1",
                  out_valid, out_result, op_count);
      end
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      test_reset();
      test_carry_zero();
      test_overflow();
      test_backpressure();
      test_back_to_back();
      test_collision();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
